// File: rtl/cmac_pkg.sv
// Shared sizing helpers for the complex MAC accumulator.
package cmac_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int calc_pw(input int a, input int b);
    return a + b + 1;
  endfunction

  function automatic int calc_accw(input int a, input int b, input int g);
    return calc_pw(a, b) + g;
  endfunction

  localparam int AWIDTH_DEF = 16;
  localparam int BWIDTH_DEF = 18;
  localparam int GUARD_DEF  = 3;
  localparam int PW_DEF     = calc_pw(AWIDTH_DEF, BWIDTH_DEF);
  localparam int ACCW_DEF   = calc_accw(AWIDTH_DEF, BWIDTH_DEF, GUARD_DEF);

endpackage

// File: rtl/complex_mac_accum_valid_delay_line.sv
// Valid-strobe shift register with sync reset and sync clear.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             d,
  output logic [DEPTH-1:0] pipe,
  output logic             q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) pipe <= '0;
    else               pipe <= (pipe << 1) | DEPTH'(d);
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/complex_mac_accum.sv
// Aligns valid to multiplier output, sums LEN complex products,
// and holds each frame sum in a single-entry valid/ready register.
module complex_mac_accum
  import cmac_pkg::*;
#(
  parameter int AWIDTH     = 16,
  parameter int BWIDTH     = 18,
  parameter int MULT_LAT   = 4,
  parameter int LEN        = 8,
  parameter int GUARD_BITS = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic signed [AWIDTH+BWIDTH:0]        pr,
  input  logic signed [AWIDTH+BWIDTH:0]        pi,
  input  logic                                 clr,
  input  logic                                 out_ready,
  output logic signed [AWIDTH+BWIDTH+GUARD_BITS:0] acc_re,
  output logic signed [AWIDTH+BWIDTH+GUARD_BITS:0] acc_im,
  output logic                                 out_valid,
  output logic                                 overrun,
  output logic                                 busy
);

  localparam int PW   = calc_pw(AWIDTH, BWIDTH);
  localparam int ACCW = PW + GUARD_BITS;
  localparam int CW   = (LEN > 1) ? clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  if (GUARD_BITS < clog2(LEN)) begin : g_guard_check
    $error("GUARD_BITS smaller than clog2(LEN)");
  end

  logic [MULT_LAT-1:0] vpipe;
  logic                p_valid;

  valid_delay_line #(.DEPTH(MULT_LAT)) u_vdl (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .d     (in_valid),
    .pipe  (vpipe),
    .q     (p_valid)
  );

  logic [CW-1:0]          cnt;
  logic signed [ACCW-1:0] acc_r, acc_i;
  logic signed [ACCW-1:0] sp_re, sp_im;
  logic signed [ACCW-1:0] sum_re, sum_im;

  assign sp_re  = ACCW'(pr);
  assign sp_im  = ACCW'(pi);
  // first product of a frame replaces the stale sum
  assign sum_re = (cnt == '0) ? sp_re : acc_r + sp_re;
  assign sum_im = (cnt == '0) ? sp_im : acc_i + sp_im;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc_r     <= '0;
      acc_i     <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clr) begin
        cnt   <= '0;
        acc_r <= '0;
        acc_i <= '0;
      end else if (p_valid) begin
        acc_r <= sum_re;
        acc_i <= sum_im;
        if (cnt == LAST) begin
          cnt       <= '0;
          acc_re    <= sum_re;
          acc_im    <= sum_im;
          out_valid <= 1'b1;
          if (out_valid && !out_ready) overrun <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (cnt != '0) || (|vpipe);

endmodule
